// File: rtl/nw_pkg.sv
// Shared NWRITE definitions for the outbound generator and the inbound receive path.
package nw_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } nw_state_e;

  // FTYPE 5 (write class), TTYPE 4 (NWRITE)
  localparam logic [7:0] NW_FTYPE_TTYPE = 8'h54;
  localparam int         NW_MAX_CHUNK   = 256;

  // HELLO header field positions (LSB of each field)
  localparam int NW_HDR_TID_LSB  = 56;
  localparam int NW_HDR_FT_LSB   = 48;
  localparam int NW_HDR_SIZE_LSB = 36;
  localparam int NW_HDR_ADDR_LSB = 0;

  // Host order is little-endian, SRIO is big-endian: byte k <- byte 7-k
  function automatic logic [63:0] nw_bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(7-k) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/nw_tx_engine_if.sv
// Command, H2C payload stream and SRIO ireq channel of the NWRITE generator.
// slave  : the engine side
// master : the command issuer / stream source / SRIO core side
interface nw_tx_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_len;

  logic        s_axis_h2c_tvalid;
  logic        s_axis_h2c_tready;
  logic [63:0] s_axis_h2c_tdata;
  logic [7:0]  s_axis_h2c_tkeep;
  logic        s_axis_h2c_tlast;

  logic        m_axis_ireq_tvalid;
  logic        m_axis_ireq_tready;
  logic [63:0] m_axis_ireq_tdata;
  logic [7:0]  m_axis_ireq_tkeep;
  logic        m_axis_ireq_tlast;
  logic [31:0] m_axis_ireq_tuser;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    input  s_axis_h2c_tvalid, s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast,
    output s_axis_h2c_tready,
    output m_axis_ireq_tvalid, m_axis_ireq_tdata, m_axis_ireq_tkeep,
           m_axis_ireq_tlast, m_axis_ireq_tuser,
    input  m_axis_ireq_tready
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    output s_axis_h2c_tvalid, s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast,
    input  s_axis_h2c_tready,
    input  m_axis_ireq_tvalid, m_axis_ireq_tdata, m_axis_ireq_tkeep,
           m_axis_ireq_tlast, m_axis_ireq_tuser,
    output m_axis_ireq_tready
  );
endinterface

// File: rtl/nw_chunk_calc.sv
// Packet size for the next NWRITE: min(256, rem), and with NW_TX_4K_SPLIT_EN
// defined also clipped to the distance to the next 4 KB boundary.
// Inputs are 8-byte aligned, so the chunk is always a whole number of beats.
module nw_chunk_calc
  import nw_pkg::*;
(
  input  logic [11:0] addr_i,
  input  logic [23:0] rem_i,
  output logic [8:0]  chunk_o,
  output logic [5:0]  beats_o
);

  logic [8:0] lim;

`ifdef NW_TX_4K_SPLIT_EN
  logic [12:0] dist;
  // bytes left before crossing a 4 KB page; 1..4096
  assign dist = 13'd4096 - {1'b0, addr_i};
`else
  logic unused_addr;
  assign unused_addr = ^addr_i;
`endif

  // smallest of the size limits that apply
  always_comb begin
    lim = (rem_i > 24'(NW_MAX_CHUNK)) ? 9'(NW_MAX_CHUNK) : rem_i[8:0];
`ifdef NW_TX_4K_SPLIT_EN
    if (dist < {4'b0, lim}) lim = dist[8:0];
`endif
  end

  assign chunk_o = lim;
  assign beats_o = lim[8:3];

endmodule

// File: rtl/nw_tx_engine.sv
// Outbound SRIO NWRITE generator: splits a (addr, len) write command into
// HELLO-format NWRITE packets of at most 256 bytes, byte-swapping the H2C
// payload into SRIO order. Optional macro NW_TX_4K_SPLIT_EN keeps every
// packet inside one 4 KB page (handled in nw_chunk_calc).
module nw_tx_engine
  import nw_pkg::*;
#(
  parameter logic [15:0] C_SRIO_DEV_ID  = 16'hF201,
  parameter logic [15:0] C_SRIO_DEST_ID = 16'h7801
) (
  input  logic             aclk,
  input  logic             aresetn,
  nw_tx_engine_if.slave    bus,
  output logic             nw_busy_o,
  output logic             nw_done_o,
  output logic             nw_err_unalign_o
);

  nw_state_e   state_q;
  logic [31:0] cur_addr_q;
  logic [23:0] rem_q;
  logic [7:0]  tid_q;
  logic [8:0]  chunk_q;
  logic [5:0]  beats_q;
  logic [5:0]  beat_cnt_q;
  logic        cmd_ready_q, busy_q, done_q, err_q;

  logic [8:0]  calc_chunk;
  logic [5:0]  calc_beats;
  logic [31:0] cur_addr_d;
  logic [23:0] rem_d;
  logic [7:0]  size_w;
  logic [63:0] hdr_w;
  logic        last_beat, beat_hs, cmd_bad;

  // payload tkeep/tlast are not needed: packet length comes from the command
  logic unused_h2c;
  assign unused_h2c = ^{bus.s_axis_h2c_tkeep, bus.s_axis_h2c_tlast};

  nw_chunk_calc u_chunk_calc (
    .addr_i  (cur_addr_q[11:0]),
    .rem_i   (rem_q),
    .chunk_o (calc_chunk),
    .beats_o (calc_beats)
  );

  assign cmd_bad    = (bus.cmd_addr[2:0] != 3'd0) || (bus.cmd_len[2:0] != 3'd0) ||
                      (bus.cmd_len == 24'd0);
  assign last_beat  = (beat_cnt_q == beats_q - 6'd1);
  assign beat_hs    = (state_q == S_DATA) && bus.s_axis_h2c_tvalid && bus.m_axis_ireq_tready;
  assign cur_addr_d = cur_addr_q + {23'd0, chunk_q};
  assign rem_d      = rem_q - {15'd0, chunk_q};
  // 256 wraps to 8'hFF as required by the size field
  assign size_w     = chunk_q[7:0] - 8'd1;

  // header beat assembled from registered packet state, stable while stalled
  always_comb begin
    hdr_w = '0;
    hdr_w[NW_HDR_TID_LSB  +: 8]  = tid_q;
    hdr_w[NW_HDR_FT_LSB   +: 8]  = NW_FTYPE_TTYPE;
    hdr_w[NW_HDR_SIZE_LSB +: 8]  = size_w;
    hdr_w[NW_HDR_ADDR_LSB +: 32] = cur_addr_q;
  end

  // ireq drive: header in S_HDR, zero-latency swapped pass-through in S_DATA
  always_comb begin
    bus.m_axis_ireq_tvalid = 1'b0;
    bus.m_axis_ireq_tdata  = '0;
    bus.m_axis_ireq_tkeep  = '0;
    bus.m_axis_ireq_tlast  = 1'b0;
    bus.m_axis_ireq_tuser  = '0;
    bus.s_axis_h2c_tready  = 1'b0;
    case (state_q)
      S_HDR: begin
        bus.m_axis_ireq_tvalid = 1'b1;
        bus.m_axis_ireq_tdata  = hdr_w;
        bus.m_axis_ireq_tkeep  = 8'hFF;
        bus.m_axis_ireq_tuser  = {C_SRIO_DEV_ID, C_SRIO_DEST_ID};
      end
      S_DATA: begin
        bus.m_axis_ireq_tvalid = bus.s_axis_h2c_tvalid;
        bus.m_axis_ireq_tdata  = nw_bswap64(bus.s_axis_h2c_tdata);
        bus.m_axis_ireq_tkeep  = 8'hFF;
        bus.m_axis_ireq_tlast  = last_beat;
        bus.m_axis_ireq_tuser  = {C_SRIO_DEV_ID, C_SRIO_DEST_ID};
        bus.s_axis_h2c_tready  = bus.m_axis_ireq_tready;
      end
      default: ;
    endcase
  end

  // command/packet sequencing FSM with registered status outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      tid_q       <= '0;
      chunk_q     <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              cur_addr_q  <= bus.cmd_addr;
              rem_q       <= bus.cmd_len;
              state_q     <= S_CALC;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        S_CALC: begin
          chunk_q    <= calc_chunk;
          beats_q    <= calc_beats;
          beat_cnt_q <= '0;
          state_q    <= S_HDR;
        end
        S_HDR: begin
          if (bus.m_axis_ireq_tready) state_q <= S_DATA;
        end
        S_DATA: begin
          if (beat_hs) begin
            beat_cnt_q <= beat_cnt_q + 6'd1;
            if (last_beat) begin
              cur_addr_q <= cur_addr_d;
              rem_q      <= rem_d;
              tid_q      <= tid_q + 8'd1;
              if (rem_d == 24'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_CALC;
              end
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign nw_busy_o        = busy_q;
  assign nw_done_o        = done_q;
  assign nw_err_unalign_o = err_q;

endmodule

// File: tb/tb_nw_tx_engine.sv
// Directed bench for nw_tx_engine with a scoreboard of expected ireq beats.
module tb_nw_tx_engine;
  import nw_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  nw_tx_engine_if bus();
  logic busy, done, err;

  nw_tx_engine dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .bus              (bus),
    .nw_busy_o        (busy),
    .nw_done_o        (done),
    .nw_err_unalign_o (err)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        is_hdr;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] src_q[$];
  int          total = 0, bad = 0;
  int          beat_cnt = 0, done_cnt = 0, hdr_cnt = 0, cyc = 0, last_tl_cyc = 0;
  logic [63:0] last_hdr = '0;
  logic [7:0]  m_tid = 8'd0;
  bit          gap_en = 1'b0, rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] sw(input logic [63:0] d);
    return {<<8{d}};
  endfunction

  // reference packetizer: expected header + swapped beats, and the payload to send
  task automatic push_cmd(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int rem, ch;
    logic [63:0] w, h;
    a = addr; rem = len;
    while (rem > 0) begin
      ch = (rem < 256) ? rem : 256;
`ifdef NW_TX_4K_SPLIT_EN
      if (4096 - int'(a[11:0]) < ch) ch = 4096 - int'(a[11:0]);
`endif
      h = {m_tid, 8'h54, 4'h0, 8'(ch - 1), 4'h0, a};
      exp_q.push_back('{h, 1'b0, 1'b1});
      for (int b = 0; b < ch / 8; b++) begin
        w = {$urandom(), $urandom()};
        src_q.push_back(w);
        exp_q.push_back('{sw(w), (b == ch / 8 - 1), 1'b0});
      end
      a = a + 32'(ch); rem = rem - ch; m_tid = m_tid + 8'd1;
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [23:0] len);
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_len = len;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge aclk); n++; end
    chk(tag, 64'(done_cnt > d0), 64'd1);
    @(negedge aclk);
    chk({tag, "_expq"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_srcq"}, 64'(src_q.size()), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_tvalid"}, 64'(bus.m_axis_ireq_tvalid), 64'd0);
    chk({tag, "_tdata"}, bus.m_axis_ireq_tdata, 64'd0);
    chk({tag, "_tkeep"}, 64'(bus.m_axis_ireq_tkeep), 64'd0);
    chk({tag, "_tlast"}, 64'(bus.m_axis_ireq_tlast), 64'd0);
    chk({tag, "_tuser"}, 64'(bus.m_axis_ireq_tuser), 64'd0);
    chk({tag, "_h2c_rdy"}, 64'(bus.s_axis_h2c_tready), 64'd0);
  endtask

  // ireq sink ready
  initial begin
    bus.m_axis_ireq_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      bus.m_axis_ireq_tready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // H2C payload source; tkeep/tlast are junk on purpose
  initial begin
    bit hs;
    bus.s_axis_h2c_tvalid = 1'b0;
    bus.s_axis_h2c_tdata  = '0;
    bus.s_axis_h2c_tkeep  = 8'h0F;
    bus.s_axis_h2c_tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      hs = bus.s_axis_h2c_tvalid && bus.s_axis_h2c_tready;
      @(posedge aclk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        if (!bus.s_axis_h2c_tvalid || hs)
          bus.s_axis_h2c_tvalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.s_axis_h2c_tdata = src_q[0];
        bus.s_axis_h2c_tlast = 1'($urandom_range(0, 1));
      end else begin
        bus.s_axis_h2c_tvalid = 1'b0;
      end
    end
  end

  // ireq monitor / scoreboard
  logic        prev_stall = 1'b0, prev_done = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.m_axis_ireq_tvalid), 64'd1);
        chk("hold_data", bus.m_axis_ireq_tdata, prev_data);
      end
      if (bus.s_axis_h2c_tready === 1'b1)
        chk("h2c_mirror", 64'(bus.m_axis_ireq_tready), 64'd1);
      if (prev_done) chk("done_pulse_width", 64'(done), 64'd0);
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_latency", 64'(cyc - last_tl_cyc), 64'd1);
      end
      if (bus.m_axis_ireq_tvalid && bus.m_axis_ireq_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk(e.is_hdr ? "hdr_data" : "beat_data", bus.m_axis_ireq_tdata, e.data);
          chk("beat_tlast", 64'(bus.m_axis_ireq_tlast), 64'(e.last));
          chk("beat_tkeep", 64'(bus.m_axis_ireq_tkeep), 64'hFF);
          chk("beat_tuser", 64'(bus.m_axis_ireq_tuser), 64'hF201_7801);
          if (e.is_hdr) begin hdr_cnt++; last_hdr = bus.m_axis_ireq_tdata; end
          if (bus.m_axis_ireq_tlast) last_tl_cyc = cyc;
        end
        beat_cnt++;
      end
      prev_stall <= bus.m_axis_ireq_tvalid && !bus.m_axis_ireq_tready;
      prev_data  <= bus.m_axis_ireq_tdata;
      prev_done  <= done;
    end else begin
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, h0, n;
    logic [31:0] bad_addr [3];
    logic [23:0] bad_len  [3];
    bad_addr = '{32'h4, 32'h0, 32'h100};
    bad_len  = '{24'd64, 24'd12, 24'd0};

    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk_idle_outs("reset");
    @(posedge aclk); #1 aresetn = 1'b1;

    // 64 B single packet, accept-to-header latency
    b0 = beat_cnt;
    push_cmd(32'h1000_0000, 64);
    issue(32'h1000_0000, 24'd64);
    @(negedge aclk);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_calc_tvalid", 64'(bus.m_axis_ireq_tvalid), 64'd0);
    chk("t1_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    chk("t1_hdr_tvalid", 64'(bus.m_axis_ireq_tvalid), 64'd1);
    wait_done("t1_done", 200);
    chk("t1_hdr_lit", last_hdr, 64'h0054_03F0_1000_0000);
    chk("t1_beats", 64'(beat_cnt - b0), 64'd9);

    // 1024 B -> 4 packets of 256 B, TID 1..4 continuing from t1
    h0 = hdr_cnt;
    push_cmd(32'h0, 1024);
    issue(32'h0, 24'd1024);
    wait_done("t2_done", 2000);
    chk("t2_pkts", 64'(hdr_cnt - h0), 64'd4);
    chk("t2_last_addr", 64'(last_hdr[31:0]), 64'h300);
    chk("t2_last_size", 64'(last_hdr[43:36]), 64'hFF);
    chk("t2_last_tid", 64'(last_hdr[63:56]), 64'd4);

    // 4 KB boundary straddle
    h0 = hdr_cnt;
    push_cmd(32'h0000_0FC0, 256);
    issue(32'h0000_0FC0, 24'd256);
    wait_done("t3_done", 1000);
`ifdef NW_TX_4K_SPLIT_EN
    chk("t3_pkts", 64'(hdr_cnt - h0), 64'd2);
    chk("t3_last_size", 64'(last_hdr[43:36]), 64'hBF);
    chk("t3_last_addr", 64'(last_hdr[31:0]), 64'h1000);
`else
    chk("t3_pkts", 64'(hdr_cnt - h0), 64'd1);
    chk("t3_last_size", 64'(last_hdr[43:36]), 64'hFF);
    chk("t3_last_addr", 64'(last_hdr[31:0]), 64'h0FC0);
`endif

    // rejected commands
    for (int i = 0; i < 3; i++) begin
      b0 = beat_cnt; d0 = done_cnt;
      issue(bad_addr[i], bad_len[i]);
      @(negedge aclk);
      chk("t4_err_pulse", 64'(err), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      @(negedge aclk);
      chk("t4_err_clear", 64'(err), 64'd0);
      repeat (5) @(negedge aclk);
      chk("t4_no_traffic", 64'(beat_cnt - b0), 64'd0);
      chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    end

    // back-pressure and source gaps over 512 B
    gap_en = 1'b1; rnd_rdy = 1'b1;
    b0 = beat_cnt;
    push_cmd(32'h0000_2000, 512);
    issue(32'h0000_2000, 24'd512);
    wait_done("t5_done", 4000);
    chk("t5_beats", 64'(beat_cnt - b0), 64'd66);
    gap_en = 1'b0; rnd_rdy = 1'b0;

    // reset in the middle of a data phase
    b0 = beat_cnt;
    push_cmd(32'h0000_3000, 512);
    issue(32'h0000_3000, 24'd512);
    n = 0;
    while (beat_cnt < b0 + 6 && n < 500) begin @(negedge aclk); n++; end
    chk("t6_reached_data", 64'(beat_cnt >= b0 + 6), 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    exp_q.delete(); src_q.delete(); m_tid = 8'd0;
    @(negedge aclk);
    chk_idle_outs("t6_in_reset");
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("t6_rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("t6_rel_busy", 64'(busy), 64'd0);
    push_cmd(32'h0000_5000, 64);
    issue(32'h0000_5000, 24'd64);
    wait_done("t6_done", 300);
    chk("t6_tid0", 64'(last_hdr[63:56]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nw_tx_engine.md
# nw_tx_engine

Outbound SRIO NWRITE generator: accepts a write command (target address, byte length) plus an H2C AXI-Stream payload and emits HELLO-format NWRITE packets on the SRIO ireq channel. Splits each command into packets of at most 256 bytes, optionally at 4 KB boundaries, with payload byte-swapped from little-endian host order to SRIO big-endian order. Sits between the DMA H2C stream and the SRIO core ireq port, opposite the inbound NWRITE receive path.

## Interface
- C_SRIO_DEV_ID, 16'hF201, source ID placed in ireq tuser[31:16]
- C_SRIO_DEST_ID, 16'h7801, destination ID placed in ireq tuser[15:0]

- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept (high only in S_IDLE)
- cmd_addr  in  32  target byte address
- cmd_len  in  24  transfer length in bytes
- nw_busy  out  1  high when state != S_IDLE
- nw_done  out  1  one-cycle pulse, command completed
- nw_err_unalign  out  1  one-cycle pulse, command rejected
- s_axis_h2c_tvalid/tready/tdata[63:0]/tkeep[7:0]/tlast  in/out/in/in/in  payload stream
- m_axis_ireq_tvalid/tready/tdata[63:0]/tkeep[7:0]/tlast/tuser[31:0]  out/in/out/out/out/out  SRIO ireq

## Operation
- States: S_IDLE, S_CALC, S_HDR, S_DATA, S_DONE.
- S_IDLE: cmd_ready=1. On cmd_valid: if cmd_addr[2:0]!=0, cmd_len[2:0]!=0, or cmd_len==0, pulse nw_err_unalign, stay S_IDLE (command consumed). Else latch cur_addr=cmd_addr, rem=cmd_len, go S_CALC.
- S_CALC (1 cycle): chunk = min(256, rem[, 4096 - cur_addr[11:0]]); beats = chunk/8; go S_HDR.
- S_HDR: drive header beat: [63:56]=TID, [55:48]=8'h54 (FTYPE 5, TTYPE 4), [47:44]=0, [43:36]=chunk-1, [35:32]=0, [31:0]=cur_addr; tkeep=8'hFF, tlast=0, tuser={C_SRIO_DEV_ID,C_SRIO_DEST_ID}. On handshake go S_DATA.
- S_DATA: ireq_tvalid=h2c_tvalid, h2c_tready=ireq_tready (combinational pass-through); ireq byte k = h2c byte 7-k; tkeep=8'hFF; tlast on beat number `beats`. h2c tlast and tkeep ignored. After last-beat handshake: cur_addr+=chunk, rem-=chunk, TID+=1 (mod 256); rem==0 → S_DONE, else S_CALC.
- S_DONE: nw_done=1 for one cycle, go S_IDLE.
- h2c_tready=0 outside S_DATA. TID persists across commands.
- Arithmetic: rem 24-bit unsigned, never underflows (chunk ≤ rem). cur_addr wraps modulo 2^32.

## Timing
- Reset values: cmd_ready=1 (S_IDLE), all other outputs 0, TID=0, internal registers 0.
- Command accept cycle N → header valid N+2 earliest. One-cycle S_CALC bubble between packets.
- Header held stable while tready=0. Data beats: zero-cycle latency h2c→ireq.
- nw_done asserted the cycle after the final beat handshake.
- Reset mid-packet: packet truncated, all state/TID cleared; SRIO core is reset together.
- cmd_valid ignored outside S_IDLE; no command queuing.

## Configuration
- NW_TX_4K_SPLIT_EN defined: chunk also bounded by distance to next 4 KB boundary; no packet crosses 4 KB.
- Undefined: chunk = min(256, rem); packets may cross 4 KB boundaries.

## Structure
- Shared package nw_pkg: state encodings, NW_FTYPE_TTYPE=8'h54, NW_MAX_CHUNK=256, header field bit positions, shared with the receive path.
- Sub-module nw_chunk_calc: combinational chunk-size/beat-count computation from cur_addr and rem, containing the NW_TX_4K_SPLIT_EN conditional.

## Test plan
- addr 32'h1000_0000, len 64 → header 64'h0054_03F0_1000_0000, tuser 32'hF201_7801, 8 swapped data beats, tlast on beat 8, nw_done pulse.
- addr 0, len 1024 → 4 packets, size field 8'hFF, addrs 0/0x100/0x200/0x300, TID 0..3; next command starts TID 4.
- addr 32'h0000_0FC0, len 256 → with NW_TX_4K_SPLIT_EN: 64 B at 0x0FC0 (size 8'h3F) then 192 B at 0x1000 (size 8'hBF); without: single 256 B packet (size 8'hFF).
- addr 32'h4 len 64, or addr 0 len 12, or len 0 → nw_err_unalign pulse, no ireq traffic, nw_done low, stays S_IDLE.
- Random ireq_tready and h2c_tvalid gaps during 512 B transfer → h2c_tready mirrors ireq_tready, header stable, every beat transferred exactly once, ordering intact.
- aresetn low mid-S_DATA → all outputs 0, cmd_ready 1 after release; next command header carries TID 0.
